// File: rtl/windowed_register_file.sv
// SPARC-style windowed integer register file: 3 combinational read ports, 1 write port,
// current-window pointer with SAVE/RESTORE and window-invalid mask trap detection.
module windowed_register_file #(
    parameter int WIDTH = 32,
    parameter int NWIN  = 4,
    parameter int CWPW  = 2
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    input  logic [4:0]       RC,
    output logic [WIDTH-1:0] PA,
    output logic [WIDTH-1:0] PB,
    output logic [WIDTH-1:0] PC,
    input  logic [4:0]       RW,
    input  logic [WIDTH-1:0] PW,
    input  logic             RF_Enable,
    input  logic             Save,
    input  logic             Restore,
    input  logic [NWIN-1:0]  WIM_In,
    input  logic             WIM_LE,
    output logic [CWPW-1:0]  CWP,
    output logic [NWIN-1:0]  WIM,
    output logic             Win_Trap,
    output logic             Trap_Type
);

    localparam int WIN_REGS = 16 * NWIN;
    localparam int DEPTH    = 8 + WIN_REGS;
    localparam int AW       = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [CWPW-1:0] cwp_dec;
    logic [CWPW-1:0] cwp_inc;
    logic [CWPW-1:0] cwp_nxt;
    logic            move_req;

    // Windowed registers wrap around the circular pool so window NWIN-1's ins alias window 0's outs.
    function automatic logic [AW-1:0] map_addr(input logic [4:0] r, input logic [CWPW-1:0] w);
        logic [AW-1:0] off;
        if (r < 5'd8)
            return AW'(r);
        off = AW'({w, 4'b0000}) + AW'(r - 5'd8);
        if (off >= AW'(WIN_REGS))
            off = off - AW'(WIN_REGS);
        return off + AW'(8);
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [4:0] r);
        if (r == 5'd0)
            return '0;
        if (wr_en && (RW == r))
            return PW;
        return regs[map_addr(r, CWP)];
    endfunction

    assign wr_en  = RF_Enable && (RW != 5'd0);
    assign wr_idx = map_addr(RW, CWP);

    assign PA = read_port(RA);
    assign PB = read_port(RB);
    assign PC = read_port(RC);

    assign cwp_dec  = (CWP == '0) ? CWPW'(NWIN - 1) : CWP - 1'b1;
    assign cwp_inc  = (CWP == CWPW'(NWIN - 1)) ? '0 : CWP + 1'b1;
    assign cwp_nxt  = Save ? cwp_dec : cwp_inc;
    assign move_req = Save ^ Restore;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= PW;
        end
    end

    // Trap check uses the mask held before the edge, even when WIM is reloaded in the same cycle.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            CWP       <= '0;
            WIM       <= '0;
            Win_Trap  <= 1'b0;
            Trap_Type <= 1'b0;
        end else begin
            Win_Trap <= 1'b0;
            if (WIM_LE)
                WIM <= WIM_In;
            if (move_req) begin
                if (WIM[cwp_nxt]) begin
                    Win_Trap  <= 1'b1;
                    Trap_Type <= Restore;
                end else begin
                    CWP <= cwp_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed and randomized bench for windowed_register_file, checked against a
// window-level model (globals, per-window ins/locals, outs aliased to the neighbour's ins).
module tb_windowed_register_file;

    localparam int WIDTH = 32;
    localparam int NWIN  = 4;
    localparam int CWPW  = 2;

    logic             Clk = 1'b0;
    logic             Clr;
    logic [4:0]       RA, RB, RC, RW;
    logic [WIDTH-1:0] PA, PB, PC, PW;
    logic             RF_Enable, Save, Restore, WIM_LE;
    logic [NWIN-1:0]  WIM_In, WIM;
    logic [CWPW-1:0]  CWP;
    logic             Win_Trap, Trap_Type;

    windowed_register_file #(.WIDTH(WIDTH), .NWIN(NWIN), .CWPW(CWPW)) dut (
        .Clk(Clk), .Clr(Clr),
        .RA(RA), .RB(RB), .RC(RC),
        .PA(PA), .PB(PB), .PC(PC),
        .RW(RW), .PW(PW), .RF_Enable(RF_Enable),
        .Save(Save), .Restore(Restore),
        .WIM_In(WIM_In), .WIM_LE(WIM_LE),
        .CWP(CWP), .WIM(WIM),
        .Win_Trap(Win_Trap), .Trap_Type(Trap_Type)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Architectural model: each window owns its ins and locals; its outs are the previous window's ins.
    logic [WIDTH-1:0] m_glob [8];
    logic [WIDTH-1:0] m_ins  [NWIN][8];
    logic [WIDTH-1:0] m_locs [NWIN][8];
    int               m_cwp;
    logic [NWIN-1:0]  m_wim;
    logic             m_trap;
    logic             m_type;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_glob[i] = '0;
        for (int w = 0; w < NWIN; w++)
            for (int i = 0; i < 8; i++) begin
                m_ins[w][i]  = '0;
                m_locs[w][i] = '0;
            end
        m_cwp  = 0;
        m_wim  = '0;
        m_trap = 1'b0;
        m_type = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] model_read(input int r);
        if (r == 0) return '0;
        if (RF_Enable && (int'(RW) == r)) return PW;
        if (r < 8)  return m_glob[r];
        if (r < 16) return m_ins[(m_cwp + NWIN - 1) % NWIN][r - 8];
        if (r < 24) return m_locs[m_cwp][r - 16];
        return m_ins[m_cwp][r - 24];
    endfunction

    task automatic model_write(input int r, input logic [WIDTH-1:0] d);
        if (r == 0) return;
        if (r < 8)       m_glob[r] = d;
        else if (r < 16) m_ins[(m_cwp + NWIN - 1) % NWIN][r - 8] = d;
        else if (r < 24) m_locs[m_cwp][r - 16] = d;
        else             m_ins[m_cwp][r - 24] = d;
    endtask

    // Applies everything the clock edge does, using the pre-edge window pointer and mask.
    task automatic model_edge();
        int nxt;
        m_trap = 1'b0;
        if (RF_Enable) model_write(int'(RW), PW);
        if (Save != Restore) begin
            nxt = Save ? (m_cwp + NWIN - 1) % NWIN : (m_cwp + 1) % NWIN;
            if (m_wim[nxt]) begin
                m_trap = 1'b1;
                m_type = Restore;
            end else begin
                m_cwp = nxt;
            end
        end
        if (WIM_LE) m_wim = WIM_In;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                                 input logic [4:0] rw, input logic [WIDTH-1:0] pw, input logic en,
                                 input logic sv, input logic rs,
                                 input logic [NWIN-1:0] wim_in, input logic wim_le);
        RA = ra; RB = rb; RC = rc; RW = rw; PW = pw; RF_Enable = en;
        Save = sv; Restore = rs; WIM_In = wim_in; WIM_LE = wim_le;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".PA"}, PA, model_read(int'(RA)));
        check({tag, ".PB"}, PB, model_read(int'(RB)));
        check({tag, ".PC"}, PC, model_read(int'(RC)));
        check({tag, ".CWP"}, WIDTH'(CWP), WIDTH'(m_cwp));
        check({tag, ".WIM"}, WIDTH'(WIM), WIDTH'(m_wim));
        check({tag, ".Win_Trap"}, WIDTH'(Win_Trap), WIDTH'(m_trap));
        check({tag, ".Trap_Type"}, WIDTH'(Trap_Type), WIDTH'(m_type));
    endtask

    // One full cycle: drive, check mid-cycle, advance the model and the clock together.
    task automatic cycle(input string tag, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                         input logic [4:0] rw, input logic [WIDTH-1:0] pw, input logic en,
                         input logic sv, input logic rs,
                         input logic [NWIN-1:0] wim_in, input logic wim_le);
        applyStimulus(ra, rb, rc, rw, pw, en, sv, rs, wim_in, wim_le);
        #4;
        checkOutput(tag);
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clr = 1'b1;
        applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        model_reset();
        @(posedge Clk);
        #1;
        checkOutput("reset");
        Clr = 1'b0;

        cycle("wr_bypass", 5'd1, 5'd0, 5'd2, 5'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle("wr_after",  5'd1, 5'd0, 5'd2, 5'd0, 32'h5,        1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle("r0_check",  5'd1, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, '0, 1'b0);

        cycle("ov_wr_r8",  5'd8,  5'd0, 5'd0, 5'd8, 32'h11, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle("ov_save",   5'd8,  5'd0, 5'd0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, '0, 1'b0);
        cycle("ov_in24",   5'd24, 5'd8, 5'd0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle("ov_out8",   5'd8,  5'd24, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        cycle("gl_wr_r5",  5'd5,  5'd16, 5'd0, 5'd5,  32'h55, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle("gl_wr_r16", 5'd5,  5'd16, 5'd0, 5'd16, 32'h66, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle("gl_save",   5'd5,  5'd16, 5'd0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b0, '0, 1'b0);
        cycle("gl_w3",     5'd5,  5'd16, 5'd0, 5'd16, 32'h77, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle("gl_restore",5'd5,  5'd16, 5'd0, 5'd0,  32'h0,  1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle("gl_w0",     5'd5,  5'd16, 5'd8, 5'd0,  32'h0,  1'b0, 1'b0, 1'b0, '0, 1'b0);

        cycle("of_wim",    5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1);
        cycle("of_save",   5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cycle("of_pulse",  5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle("of_clear",  5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1);

        cycle("uf_restore",5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle("uf_both",   5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
        cycle("uf_oldwim", 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
        cycle("uf_pulse",  5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle("uf_move",   5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] pick;
            logic [NWIN-1:0] wim_rand;
            pick     = 4'($urandom_range(0, 15));
            wim_rand = (pick < 4'd8) ? NWIN'(1 << $urandom_range(0, NWIN - 1)) : '0;
            cycle("random",
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 32'($urandom), 1'($urandom_range(0, 1)),
                  (pick inside {[4'd0:4'd4]}), (pick inside {[4'd3:4'd7]}),
                  wim_rand, (pick == 4'd9) || (pick == 4'd15));
        end

        cycle("rst_prep", 5'd20, 5'd8, 5'd1, 5'd20, 32'hCAFE0001, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        applyStimulus(5'd20, 5'd8, 5'd1, 5'd0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        Clr = 1'b1;
        #1;
        model_reset();
        checkOutput("async_rst");
        #1;
        Clr = 1'b0;
        @(posedge Clk);
        #1;
        cycle("post_rst", 5'd20, 5'd8, 5'd1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/windowed_register_file.md
Name: windowed_register_file

Overview:
- Parametrised successor to the single general/special registers: a SPARC-style windowed integer register file.
- Provides 3 combinational read ports, 1 clocked write port, a current-window pointer (CWP) with SAVE/RESTORE, and a window-invalid mask (WIM) with overflow/underflow trap detection.
- Sits in the ID stage. Reads feed the operand muxes toward ID/EX; writes come from MEM/WB (PW, RW, RF_Enable).

Parameters:
- WIDTH, 32, data width of every register.
- NWIN, 4, number of register windows (2..32). Physical depth = 8 + 16*NWIN.
- CWPW, 2, width of CWP; must equal ceil(log2(NWIN)).

Ports:
- Clk  input  1  rising-edge clock.
- Clr  input  1  asynchronous, active-high reset.
- RA  input  5  architectural register address, port A.
- RB  input  5  architectural register address, port B.
- RC  input  5  architectural register address, port C (store data).
- PA  output  WIDTH  read data, port A.
- PB  output  WIDTH  read data, port B.
- PC  output  WIDTH  read data, port C.
- RW  input  5  write address.
- PW  input  WIDTH  write data.
- RF_Enable  input  1  write enable.
- Save  input  1  request CWP decrement.
- Restore  input  1  request CWP increment.
- WIM_In  input  NWIN  new window-invalid mask.
- WIM_LE  input  1  load enable for WIM.
- CWP  output  CWPW  current window pointer.
- WIM  output  NWIN  current mask.
- Win_Trap  output  1  one-cycle trap pulse.
- Trap_Type  output  1  0 = overflow (SAVE), 1 = underflow (RESTORE); valid when Win_Trap = 1.

Behaviour:
- Reset:
  - Clr is asynchronous and active-high; it takes effect immediately, including mid-operation.
  - All physical registers = 0, CWP = 0, WIM = 0, Win_Trap = 0, Trap_Type = 0.
- Address mapping for architectural register r:
  - r0..r7 (globals) map to physical 0..7, shared by all windows.
  - r8..r31 map to physical 8 + ((CWP*16 + (r-8)) mod (16*NWIN)).
  - Consequence: ins (r24..r31) of window w are the same physical registers as the outs (r8..r15) of window (w+1) mod NWIN.
  - Locals (r16..r23) are private to each window.
- Reads:
  - Combinational from the current CWP.
  - Address 0 always reads 0.
- Write-first bypass: if RF_Enable = 1, RW = Rx and RW != 0, port x returns PW in the same cycle. Bypass uses the same CWP for both read and write mapping.
- Writes:
  - Occur on the rising edge of Clk when RF_Enable = 1 and RW != 0.
  - The write is mapped using the CWP value held before that edge.
  - A write to r0 is discarded.
- SAVE:
  - nxt = (CWP - 1) mod NWIN, so 0 wraps to NWIN-1.
  - If WIM[nxt] = 0: CWP <= nxt at the edge.
  - If WIM[nxt] = 1: CWP unchanged; Win_Trap = 1 and Trap_Type = 0 on the following cycle.
- RESTORE:
  - nxt = (CWP + 1) mod NWIN.
  - If WIM[nxt] = 0: CWP <= nxt at the edge.
  - If WIM[nxt] = 1: CWP unchanged; Win_Trap = 1 and Trap_Type = 1 on the following cycle.
- Save and Restore both asserted: no CWP change, no trap.
- Win_Trap is registered:
  - high for exactly one cycle per trapping request;
  - back-to-back trapping requests give consecutive pulses;
  - Trap_Type holds its last value while Win_Trap = 0.
- WIM_LE: WIM <= WIM_In at the edge. A SAVE/RESTORE in the same cycle checks the old WIM.
- Write together with SAVE/RESTORE in the same cycle: the write uses the old CWP, and the new CWP takes effect from the next cycle.
- Latency summary: read = 0 cycles; write visible through the array on the next cycle (same cycle via bypass); CWP update = 1 edge.

Test Plan:
- Reset: Clr pulsed asynchronously mid-cycle after writes → PA/PB/PC = 0 and CWP = 0 immediately, before the next Clk edge.
- Write/bypass/r0: RW=1, PW=0xDEADBEEF, RF_Enable=1, RA=1 → PA=0xDEADBEEF in the same cycle and after the edge. RW=0, PW=0x5 → RB=0 reads 0.
- Window overlap (NWIN=4): at CWP=0 write r8=0x11; Save → CWP=3; RA=24 → 0x11. Restore → CWP=0; RA=8 → 0x11.
- Globals/locals: at CWP=0 write r5=0x55 and r16=0x66; Save → CWP=3; r5 reads 0x55, r16 reads 0. Write r16=0x77; Restore → r16 reads 0x66.
- Overflow trap: WIM=4'b1000, CWP=0, Save → next cycle Win_Trap=1, Trap_Type=0, CWP=0; the cycle after that Win_Trap=0.
- Underflow/simultaneous: WIM=4'b0010, CWP=0, Restore → Win_Trap=1, Trap_Type=1, CWP=0. Save+Restore together → CWP unchanged, no trap. WIM_LE with WIM_In=0 in the same cycle as Restore → still traps (old WIM is used).
